// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_pkg
//  Description : Shared types and constants for the instruction-fetch
//                controller: FSM state encoding, instruction width, PC
//                increment, and a small alignment helper.
//  Ports       : none (package)
//  Revision    : 1.0  initial release
// ============================================================================
package fetch_pkg;

  // Fetch controller states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    ERR   = 2'd2
  } fetch_state_e;

  localparam int INSTR_W = 32;
  localparam int PC_INC  = 4;

  // Instructions are word aligned, so any nonzero low bits in a target
  // are unrecoverable.
  function automatic logic is_misaligned(input logic [1:0] addr_lsb);
    return (addr_lsb != 2'b00);
  endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_outbuf.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_outbuf
//  Description : One-entry valid/stall buffer between the fetch controller
//                and decode. Holds the fetched instruction and its PC.
//                Priority of controls: flush > load > handoff.
//  Ports       : clk, reset (sync, active-low)
//                load_i   - capture instr_i/pc_i, mark valid
//                flush_i  - drop contents (redirect or error)
//                stall_i  - decode cannot accept this cycle
//                instr_i, pc_i      - data to capture
//                instr_o, pc_o, valid_o - buffer contents toward decode
//                free_o   - buffer can take a new entry at the next edge
//  Revision    : 1.0  initial release
// ============================================================================
module fetch_outbuf
  import fetch_pkg::*;
#(
  parameter int N = 64
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load_i,
  input  logic               flush_i,
  input  logic               stall_i,
  input  logic [INSTR_W-1:0] instr_i,
  input  logic [N-1:0]       pc_i,
  output logic [INSTR_W-1:0] instr_o,
  output logic [N-1:0]       pc_o,
  output logic               valid_o,
  output logic               free_o
);

  logic               valid_q, valid_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [N-1:0]       pc_q,    pc_d;
  logic               w_handoff;

  // Decode takes the entry this cycle.
  assign w_handoff = valid_q && !stall_i;
  // Free when empty, or when the current entry leaves at this edge.
  assign free_o    = !valid_q || w_handoff;

  always_comb begin
    valid_d = valid_q;
    instr_d = instr_q;
    pc_d    = pc_q;
    if (w_handoff) begin
      valid_d = 1'b0;
    end
    if (load_i) begin
      valid_d = 1'b1;
      instr_d = instr_i;
      pc_d    = pc_i;
    end
    // A flush in the same cycle as a handoff still lets decode take the
    // entry; the buffer is simply left empty afterwards.
    if (flush_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      valid_q <= 1'b0;
      instr_q <= '0;
      pc_q    <= '0;
    end else begin
      valid_q <= valid_d;
      instr_q <= instr_d;
      pc_q    <= pc_d;
    end
  end

  assign instr_o = instr_q;
  assign pc_o    = pc_q;
  assign valid_o = valid_q;

endmodule
`default_nettype wire

// File: rtl/fetch_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_ctrl
//  Description : Instruction-fetch sequencer. Owns the PC, issues sequential
//                and redirected fetches over a req/ack handshake to a
//                variable-latency instruction memory, squashes in-flight
//                fetches on redirect and feeds decode through a one-entry
//                buffer. Timeouts and misaligned targets lock into a sticky
//                error state until reset.
//  Ports       : clk, reset (sync, active-low)
//                PCSrc_F, PCBranch_F     - redirect request / target
//                stall_D                 - decode backpressure
//                imem_req, imem_addr     - memory request / address
//                imem_ack, imem_rdata    - memory response
//                instr_D, pc_D, valid_D  - buffered instruction to decode
//                fetch_err               - sticky error flag
//  Revision    : 1.0  initial release
// ============================================================================
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int             N        = 64,
  parameter logic [N-1:0]   RESET_PC = '0,
  parameter int             MAX_WAIT = 15
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               PCSrc_F,
  input  logic [N-1:0]       PCBranch_F,
  input  logic               stall_D,
  output logic               imem_req,
  output logic [N-1:0]       imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [INSTR_W-1:0] instr_D,
  output logic [N-1:0]       pc_D,
  output logic               valid_D,
  output logic               fetch_err
);

  localparam int                c_WAIT_W   = $clog2(MAX_WAIT + 1);
  localparam logic [c_WAIT_W-1:0] c_MAX_WAIT = c_WAIT_W'(MAX_WAIT);

  fetch_state_e         state_q, state_d;
  logic [N-1:0]         pc_q, pc_d;
  logic [N-1:0]         redir_tgt_q, redir_tgt_d;
  logic                 redir_pend_q, redir_pend_d;
  logic                 busy_q, busy_d;        // request issued, not yet acked
  logic [c_WAIT_W-1:0]  wait_cnt_q, wait_cnt_d;

  logic                 w_buf_free;
  logic                 w_buf_load;
  logic                 w_buf_flush;
  logic                 w_redir;
  logic                 w_misalign;
  logic                 w_timeout;
  logic [c_WAIT_W-1:0]  w_wait_inc;

  // Redirects are ignored once the error state is entered.
  assign w_redir    = PCSrc_F && (state_q != ERR);
  assign w_misalign = w_redir && is_misaligned(PCBranch_F[1:0]);
  assign w_wait_inc = wait_cnt_q + 1'b1;
  assign w_timeout  = imem_req && !imem_ack && (w_wait_inc == c_MAX_WAIT);

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next state
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    state_d = w_misalign ? ERR : FETCH;
      FETCH:   if (w_misalign || w_timeout) state_d = ERR;
      ERR:     state_d = ERR;
      default: state_d = ERR;
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM: outputs
  // --------------------------------------------------------------------------
  // A request already on the bus stays up regardless of stall; a new one
  // only starts when the output buffer can take its result.
  always_comb begin
    imem_req  = 1'b0;
    fetch_err = 1'b0;
    unique case (state_q)
      FETCH:   imem_req  = busy_q || w_buf_free;
      ERR:     fetch_err = 1'b1;
      default: ;
    endcase
  end

  // The PC only moves on ack or on a redirect with nothing on the bus, so
  // it doubles as a stable request address.
  assign imem_addr = pc_q;

  // --------------------------------------------------------------------------
  // PC / redirect / wait-counter next state
  // --------------------------------------------------------------------------
  always_comb begin
    pc_d         = pc_q;
    redir_tgt_d  = redir_tgt_q;
    redir_pend_d = redir_pend_q;
    busy_d       = busy_q;
    wait_cnt_d   = wait_cnt_q;
    w_buf_load   = 1'b0;

    if (imem_req) begin
      if (imem_ack) begin
        busy_d     = 1'b0;
        wait_cnt_d = '0;
        if (w_redir) begin
          // Redirect coincides with the ack: newest target wins, data dropped.
          pc_d         = PCBranch_F;
          redir_pend_d = 1'b0;
        end else if (redir_pend_q) begin
          // Squashed fetch finally returned: drop it and jump.
          pc_d         = redir_tgt_q;
          redir_pend_d = 1'b0;
        end else begin
          pc_d       = pc_q + N'(PC_INC);
          w_buf_load = 1'b1;
        end
      end else begin
        busy_d     = 1'b1;
        wait_cnt_d = w_wait_inc;
        if (w_redir) begin
          // Cannot abandon the bus; remember where to go once it completes.
          redir_pend_d = 1'b1;
          redir_tgt_d  = PCBranch_F;
        end
      end
    end else if (w_redir) begin
      pc_d = PCBranch_F;
    end
  end

  assign w_buf_flush = w_redir || (state_d == ERR);

  always_ff @(posedge clk) begin
    if (!reset) begin
      pc_q         <= RESET_PC;
      redir_tgt_q  <= '0;
      redir_pend_q <= 1'b0;
      busy_q       <= 1'b0;
      wait_cnt_q   <= '0;
    end else begin
      pc_q         <= pc_d;
      redir_tgt_q  <= redir_tgt_d;
      redir_pend_q <= redir_pend_d;
      busy_q       <= busy_d;
      wait_cnt_q   <= wait_cnt_d;
    end
  end

  // --------------------------------------------------------------------------
  // Output buffer toward decode
  // --------------------------------------------------------------------------
  fetch_outbuf #(
    .N (N)
  ) u_outbuf (
    .clk     (clk),
    .reset   (reset),
    .load_i  (w_buf_load),
    .flush_i (w_buf_flush),
    .stall_i (stall_D),
    .instr_i (imem_rdata),
    .pc_i    (pc_q),
    .instr_o (instr_D),
    .pc_o    (pc_D),
    .valid_o (valid_D),
    .free_o  (w_buf_free)
  );

endmodule
`default_nettype wire
